decode_regfile_sext: RTL and testbench

Decode-stage datapath block. It combines a 32x32 general-purpose register file (two read ports, one write port) with a 16-to-32-bit immediate sign extender. Read data and the extended immediate are captured into ID-stage output registers that hold while the pipeline is stalled. Writes arrive from the write-back stage and are never blocked by the stall.

---
 rtl/decode_regfile_sext_pkg.sv | 8 +
 rtl/decode_regfile_sext_if.sv | 25 ++
 rtl/decode_regfile_sext_imm_sign_extend.sv | 9 +
 rtl/decode_regfile_sext.sv | 39 +++
 tb/tb_decode_regfile_sext.sv | 111 +++++++++++
 5 files changed

// File: rtl/decode_regfile_sext_pkg.sv
// decode_regfile_sext_pkg: shared widths and constants for the decode-stage datapath
package decode_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W = 16;
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/decode_regfile_sext_if.sv
// decode_regfile_sext_if: decode-stage read/write-back/immediate bus
interface decode_regfile_sext_if;
  import decode_pkg::*;
  logic stall_flag;
  logic [ADDR_W-1:0] inst_read_reg_addr1;
  logic [ADDR_W-1:0] inst_read_reg_addr2;
  logic [ADDR_W-1:0] reg_wr_addr_wb;
  logic [DATA_W-1:0] reg_wr_data;
  logic reg_write;
  logic [IMM_W-1:0] inst_imm_field;
  logic [DATA_W-1:0] reg_file_rd_data1;
  logic [DATA_W-1:0] reg_file_rd_data2;
  logic [DATA_W-1:0] sgn_ext_imm;
  logic [DATA_W-1:0] imm_sgn_ext_lft_shft;
  modport master (
    output stall_flag, inst_read_reg_addr1, inst_read_reg_addr2, reg_wr_addr_wb,
           reg_wr_data, reg_write, inst_imm_field,
    input  reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm, imm_sgn_ext_lft_shft
  );
  modport slave (
    input  stall_flag, inst_read_reg_addr1, inst_read_reg_addr2, reg_wr_addr_wb,
           reg_wr_data, reg_write, inst_imm_field,
    output reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm, imm_sgn_ext_lft_shft
  );
endinterface

// File: rtl/decode_regfile_sext_imm_sign_extend.sv
// imm_sign_extend: combinational 16->32 immediate sign extension
module imm_sign_extend
  import decode_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] ext
);
  assign ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
endmodule

// File: rtl/decode_regfile_sext.sv
// decode_regfile_sext: 32x32 register file with registered read ports and sign-extended immediate
module decode_regfile_sext
  import decode_pkg::*;
(
  input logic clk,
  input logic reset,
  decode_regfile_sext_if.slave bus
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, imm_ext;
  imm_sign_extend u_sext (.imm(bus.inst_imm_field), .ext(imm_ext));
  // reads come from the post-write array, which gives write-through bypass for free
  always_comb begin
    regs_d = regs_q;
    if (bus.reg_write && bus.reg_wr_addr_wb != ZERO_REG) regs_d[bus.reg_wr_addr_wb] = bus.reg_wr_data;
    regs_d[ZERO_REG] = '0;
    rd1_d = bus.stall_flag ? rd1_q : regs_d[bus.inst_read_reg_addr1];
    rd2_d = bus.stall_flag ? rd2_q : regs_d[bus.inst_read_reg_addr2];
    imm_d = bus.stall_flag ? imm_q : imm_ext;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      imm_q <= imm_d;
    end
  end
  assign bus.reg_file_rd_data1 = rd1_q;
  assign bus.reg_file_rd_data2 = rd2_q;
  assign bus.sgn_ext_imm = imm_q;
  assign bus.imm_sgn_ext_lft_shft = imm_q << 2;
endmodule

// File: tb/tb_decode_regfile_sext.sv
// tb_decode_regfile_sext: scoreboard bench with a behavioural register-file model
module tb_decode_regfile_sext;
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] sh;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int compared = 0;
  int mismatched = 0;
  exp_t q[$];
  exp_t last;
  logic [31:0] mdl [32];
  decode_regfile_sext_if bus();
  decode_regfile_sext dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.stall_flag = 0;
    bus.inst_read_reg_addr1 = 0;
    bus.inst_read_reg_addr2 = 0;
    bus.reg_wr_addr_wb = 0;
    bus.reg_wr_data = 0;
    bus.reg_write = 0;
    bus.inst_imm_field = 0;
  end
  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 0;
      last = '{d1: 0, d2: 0, imm: 0, sh: 0};
    end else begin
      if (bus.reg_write && bus.reg_wr_addr_wb != 0) mdl[bus.reg_wr_addr_wb] = bus.reg_wr_data;
      if (!bus.stall_flag) begin
        last.d1 = mdl[bus.inst_read_reg_addr1];
        last.d2 = mdl[bus.inst_read_reg_addr2];
        last.imm = 32'(int'($signed(bus.inst_imm_field)));
        last.sh = 32'(int'($signed(bus.inst_imm_field)) * 4);
      end
    end
    e = last;
    q.push_back(e);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("rd_data1", bus.reg_file_rd_data1, e.d1);
      check("rd_data2", bus.reg_file_rd_data2, e.d2);
      check("sgn_ext_imm", bus.sgn_ext_imm, e.imm);
      check("imm_shift", bus.imm_sgn_ext_lft_shft, e.sh);
    end
  end
  task automatic cyc(input logic rs, input logic st, input logic we, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [15:0] imm);
    @(negedge clk);
    #1;
    reset = rs;
    bus.stall_flag = st;
    bus.reg_write = we;
    bus.inst_read_reg_addr1 = a1;
    bus.inst_read_reg_addr2 = a2;
    bus.reg_wr_addr_wb = wa;
    bus.reg_wr_data = wd;
    bus.inst_imm_field = imm;
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 31, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 5, 32'hDEADBEEF, 0);
    cyc(0, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 7, 7, 32'h12345678, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 0);
    cyc(0, 0, 0, 7, 0, 0, 0, 16'h8004);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h7FFF);
    cyc(0, 0, 1, 10, 10, 10, 32'hA, 16'h1111);
    cyc(0, 1, 1, 4, 3, 3, 32'h55, 16'hF234);
    cyc(0, 1, 0, 9, 3, 0, 0, 16'h0001);
    cyc(0, 0, 0, 3, 10, 0, 0, 16'h0002);
    for (int i = 1; i < 32; i++)
      cyc(i == 20, 0, 1, 5'(i - 1), 5'(32 - i), 5'(i), 32'h1000_0000 + 32'(i), 16'(i));
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 16'hFFFF);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1) ? wa : 5'($urandom), ($urandom_range(0, 1) == 1) ? wa : 5'($urandom),
          wa, $urandom, 16'($urandom));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
